// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the control unit and seq_alu.
// The master drives operands and START; the slave (the ALU) returns result and status.
interface seq_alu_if;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] select;
  logic       start;
  logic [7:0] result;
  logic       zero;
  logic       busy;
  logic       done;

  modport master (
    output data1, data2, select, start,
    input  result, zero, busy, done
  );

  modport slave (
    input  data1, data2, select, start,
    output result, zero, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle 8-bit execution unit: logic ops finish on the acceptance edge,
// MUL and shifts iterate one step per clock, with a START/BUSY/DONE handshake.
module seq_alu (
  input  logic      clk_i,
  input  logic      rst_ni,
  seq_alu_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] OP_FWD = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_ROR = 3'd7;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] work_q, work_d;
  logic [7:0] mplr_q, mplr_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic       zero_q, zero_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [3:0] amt_s;
  logic [7:0] acc_step_s;
  logic [7:0] step_s;

  // SLL/SRA saturate at 8 steps; ROR only uses the low three bits
  function automatic logic [3:0] shift_amount(input logic [2:0] op, input logic [7:0] b);
    logic [3:0] amt;
    if (op == OP_ROR) begin
      amt = {1'b0, b[2:0]};
    end else if (b[7:3] != 5'd0) begin
      amt = 4'd8;
    end else begin
      amt = {1'b0, b[2:0]};
    end
    return amt;
  endfunction

  function automatic logic [7:0] single_op(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [7:0] r;
    case (op)
      OP_FWD:  r = b;
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] shift_step(input logic [2:0] op, input logic [7:0] w);
    logic [7:0] r;
    case (op)
      OP_SLL:  r = {w[6:0], 1'b0};
      OP_SRA:  r = {w[7], w[7:1]};
      OP_ROR:  r = {w[0], w[7:1]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    work_d     = work_q;
    mplr_d     = mplr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_d     = zero_q;
    amt_s      = shift_amount(bus.select, bus.data2);
    acc_step_s = mplr_q[0] ? (acc_q + work_q) : acc_q;
    step_s     = 8'd0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d   = bus.select;
          work_d = bus.data1;
          mplr_d = bus.data2;
          if (bus.select == OP_MUL) begin
            acc_d   = 8'd0;
            cnt_d   = 4'd8;
            state_d = ST_EXEC;
          end else if (bus.select[2] == 1'b1) begin
            if (amt_s == 4'd0) begin
              result_d = bus.data1;
              zero_d   = (bus.data1 == 8'd0);
              state_d  = ST_DONE;
            end else begin
              cnt_d   = amt_s;
              state_d = ST_EXEC;
            end
          end else begin
            result_d = single_op(bus.select, bus.data1, bus.data2);
            zero_d   = (single_op(bus.select, bus.data1, bus.data2) == 8'd0);
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (op_q == OP_MUL) begin
          acc_d  = acc_step_s;
          work_d = {work_q[6:0], 1'b0};
          mplr_d = {1'b0, mplr_q[7:1]};
          step_s = acc_step_s;
        end else begin
          work_d = shift_step(op_q, work_q);
          step_s = shift_step(op_q, work_q);
        end
        if (cnt_q == 4'd1) begin
          result_d = step_s;
          zero_d   = (step_s == 8'd0);
          state_d  = ST_DONE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'd0;
      work_q   <= 8'd0;
      mplr_q   <= 8'd0;
      acc_q    <= 8'd0;
      cnt_q    <= 4'd0;
      result_q <= 8'd0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu plus hand-written handshake and
// mid-operation reset sequences.
module tb_seq_alu;

  localparam logic [2:0] OP_FWD = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_ROR = 3'd7;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks_total;
  int   checks_passed;

  seq_alu_if bus ();

  seq_alu dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation, wait for DONE (bounded) and check result/zero/latency/busy.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.data1  = v.a;
    bus.data2  = v.b;
    bus.select = v.op;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.data1  = 8'($urandom);
    bus.data2  = 8'($urandom);
    bus.select = 3'($urandom);
    lat      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    check({tag, "_result"}, {24'd0, bus.result}, {24'd0, v.res});
    check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, (v.res == 8'd0)});
    check({tag, "_latency"}, lat, {28'd0, v.lat});
    check({tag, "_busy_cycles"}, busy_cnt, {28'd0, v.lat} + 32'd1);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    vec_t vecs[17];
    vec_t v;
    int   done_cnt;
    int   guard;

    checks_total  = 0;
    checks_passed = 0;

    vecs[0]  = '{OP_ADD, 8'h05, 8'h03, 8'h08, 4'd0};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'd0};
    vecs[2]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'd0};
    vecs[3]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'd0};
    vecs[4]  = '{OP_FWD, 8'h11, 8'h5A, 8'h5A, 4'd0};
    vecs[5]  = '{OP_MUL, 8'h0D, 8'h0B, 8'h8F, 4'd8};
    vecs[6]  = '{OP_MUL, 8'h10, 8'h10, 8'h00, 4'd8};
    vecs[7]  = '{OP_SLL, 8'h81, 8'h01, 8'h02, 4'd1};
    vecs[8]  = '{OP_SRA, 8'h80, 8'h03, 8'hF0, 4'd3};
    vecs[9]  = '{OP_SRA, 8'h80, 8'h20, 8'hFF, 4'd8};
    vecs[10] = '{OP_ROR, 8'h01, 8'h09, 8'h80, 4'd1};
    vecs[11] = '{OP_SLL, 8'h3C, 8'h00, 8'h3C, 4'd0};
    vecs[12] = '{OP_SRA, 8'h40, 8'h20, 8'h00, 4'd8};
    vecs[13] = '{OP_ROR, 8'h96, 8'h0B, 8'hD2, 4'd3};
    vecs[14] = '{OP_SLL, 8'h81, 8'hFF, 8'h00, 4'd8};
    vecs[15] = '{OP_SRA, 8'h80, 8'h00, 8'h80, 4'd0};
    vecs[16] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 4'd8};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.data1  = 8'd0;
    bus.data2  = 8'd0;
    bus.select = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_result", {24'd0, bus.result}, 32'h00);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i], $sformatf("v%0d", i));
    end

    // START held through MUL EXEC and the DONE cycle must be ignored
    @(negedge clk);
    bus.data1  = 8'h0D;
    bus.data2  = 8'h0B;
    bus.select = OP_MUL;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.data1  = 8'h01;
    bus.data2  = 8'h01;
    bus.select = OP_ADD;
    guard = 0;
    while (bus.done !== 1'b1 && guard < 20) begin
      check("hold_result_stable", {24'd0, bus.result}, 32'h01);
      @(negedge clk);
      guard++;
    end
    check("hold_latency", guard, 32'd8);
    check("hold_mul_result", {24'd0, bus.result}, 32'h8F);
    @(negedge clk);
    bus.start = 1'b0;
    check("hold_done_ignored", {30'd0, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    check("hold_result_kept", {24'd0, bus.result}, 32'h8F);

    // Continuous START on a 1-step shift: one acceptance every 3 edges
    bus.data1  = 8'h81;
    bus.data2  = 8'h01;
    bus.select = OP_SLL;
    bus.start  = 1'b1;
    done_cnt   = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    bus.start = 1'b0;
    check("cont_done_count", done_cnt, 32'd4);
    check("cont_result", {24'd0, bus.result}, 32'h02);
    repeat (2) @(negedge clk);
    check("cont_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    // Reset during EXEC step 4 of a MUL
    bus.data1  = 8'h0D;
    bus.data2  = 8'h0B;
    bus.select = OP_MUL;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    check("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_result", {24'd0, bus.result}, 32'h00);
    check("midrst_zero", {31'd0, bus.zero}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 32'd0);
    rst_n = 1'b1;
    v = '{OP_ADD, 8'h12, 8'h34, 8'h46, 4'd0};
    run_op(v, "post_rst_add");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle 8-bit execution unit that sits directly downstream of the register file. It takes the two register read ports as operands and produces one 8-bit result for write-back. Single-cycle ops (forward, add, and, or) finish immediately; multiply and shifts iterate one step per clock. A START/BUSY/DONE handshake lets the control unit stall the pipeline until the result is ready.

## Interface

Parameters: none (datapath fixed at 8 bits, 3-bit opcode).

- CLK  input  1  system clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately
- DATA1  input  8  operand A (register file read port 1)
- DATA2  input  8  operand B / shift amount (register file read port 2)
- SELECT  input  3  opcode, sampled with START
- START  input  1  request; accepted only in IDLE
- RESULT  output  8  registered result; feeds register file write data
- ZERO  output  1  registered, high when RESULT == 0
- BUSY  output  1  high whenever state != IDLE
- DONE  output  1  one-cycle pulse; RESULT/ZERO valid and newly updated

## Operation

- Opcodes: 000 FWD (B), 001 ADD (A+B mod 256), 010 AND, 011 OR, 100 MUL (unsigned A*B, low 8 bits), 101 SLL (A << B), 110 SRA (A >>> B, sign fill), 111 ROR (A rotated right by B[2:0]).
- SLL/SRA amount = B saturated to 8: B ≥ 8 gives SLL = 0x00, SRA = 0x00 or 0xFF by A[7]. ROR uses B[2:0] only; upper bits ignored.
- States: IDLE, EXEC, DONE.
- IDLE + START=1 on an edge (acceptance edge E0):
  - Latch A, B and op into internal registers. DATA1/DATA2/SELECT are don't-care after E0.
  - Single-cycle ops, or a shift with amount 0: compute, load RESULT/ZERO, go to DONE.
  - MUL: load iteration count 8, clear accumulator, go to EXEC.
  - Shift with amount n ≥ 1: load count n, copy A into the working register, go to EXEC.
- EXEC, each edge: perform one step and decrement count.
  - MUL step: if multiplier LSB, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1.
  - Shift step: shift or rotate the working register by 1.
  - On the step where count reaches 0: load RESULT/ZERO from the working value, go to DONE.
- DONE: DONE=1 for exactly one cycle, then IDLE on the next edge.
- START outside IDLE (EXEC or DONE) is ignored, not queued.
- RESULT and ZERO hold their last value until the next DONE. Intermediate values never appear on RESULT.
- RESET low at any time, including mid-EXEC: abort the operation and go to IDLE.
  - Reset values: RESULT=0x00, ZERO=1, BUSY=0, DONE=0; count and internal registers cleared.
  - After RESET deasserts, the first START is accepted normally.

## Timing

- Latency L (edges after E0 before RESULT updates): 0 for FWD/ADD/AND/OR and zero-amount shifts; n (1..8) for shifts; 8 for MUL.
- RESULT/ZERO update and DONE rises on edge E0+L. DONE is high for the cycle between edges E0+L and E0+L+1.
- BUSY rises on E0 and falls on E0+L+1, together with DONE.
- Next START can be accepted on edge E0+L+1 at the earliest, giving a minimum issue interval of L+2 edges... more precisely, a new START sampled on edge E0+L+1 is ignored, because the state is still DONE at that edge. The first acceptable edge is E0+L+2.
- No combinational path from any input to any output.
- Asynchronous reset assertion takes effect without a clock. Deassertion is assumed synchronized upstream.

## Test plan

- Reset: hold RESET low, toggle CLK -> RESULT=0x00, ZERO=1, BUSY=0, DONE=0. Release, START ADD A=0x05 B=0x03 -> DONE on E0, RESULT=0x08, ZERO=0.
- Single-cycle ops: ADD 0xFF+0x01 -> RESULT=0x00, ZERO=1 (wrap). AND 0xF0&0x3C -> 0x30. OR 0xF0|0x0F -> 0xFF. FWD B=0x5A -> 0x5A.
- MUL: A=0x0D, B=0x0B -> RESULT=0x8F after exactly 8 EXEC edges, BUSY high for 9 cycles. A=0x10, B=0x10 -> 0x00, ZERO=1.
- Shifts:
  - SLL A=0x81 B=1 -> 0x02 (L=1).
  - SRA A=0x80 B=3 -> 0xF0 (L=3).
  - SRA A=0x80 B=0x20 -> 0xFF (L=8).
  - ROR A=0x01 B=0x09 -> 0x80 (amount 1).
  - SLL B=0 -> A, DONE on E0.
- Handshake: pulse START repeatedly during MUL EXEC and on the DONE cycle -> ignored. RESULT unchanged until DONE. A START held continuously -> accepted on every (L+2)th edge.
- Reset mid-op: assert RESET at EXEC step 4 of a MUL -> outputs take their reset values immediately and no DONE pulse appears. After release, a new ADD completes correctly.
